// File: rtl/ifsram_pd_sched.sv
// ifsram_pd_sched: per-tile sequencer for the ifmap SRAM edge buffers
// (buf0, buf1, buf6, buf7). Runs the loader phase and then, for edge or
// first-slice tiles, the padding phase. It owns the shared SRAM write port
// and hands it to whichever engine is active. A phase watchdog and sticky
// error flags report stuck engines and write-port ownership violations.
module ifsram_pd_sched #(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 64,
  parameter int unsigned TO_BITS    = 10,
  parameter int unsigned PD_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tile_start,
  input  logic [2:0]        tile_mast,
  input  logic              err_clr,
  output logic              tile_busy,
  output logic              tile_done,
  output logic [1:0]        tile_err,
  output logic              ld_start,
  input  logic              ld_done,
  output logic              pd_start,
  input  logic              pd_done,
  input  logic [3:0]        ld_cen,
  input  logic [3:0]        ld_wen,
  input  logic [4*AW-1:0]   ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic [3:0]        pd_cen,
  input  logic [3:0]        pd_wen,
  input  logic [4*AW-1:0]   pd_addr,
  input  logic [DW-1:0]     pd_data,
  output logic [3:0]        sr_cen,
  output logic [3:0]        sr_wen,
  output logic [4*AW-1:0]   sr_addr,
  output logic [DW-1:0]     sr_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PADST = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Watchdog fires when the next count would reach this value, so a phase
  // may occupy at most PD_TIMEOUT cycles.
  localparam logic [TO_BITS-1:0] TIMEOUT_C = TO_BITS'(PD_TIMEOUT);

  // Master states LEFT(1), RIGH(3) and FSLD(7) need the padding phase; all
  // other codes behave like NORMAL.
  function automatic logic f_needs_pad(input logic [2:0] mast);
    logic res;
    case (mast)
      3'd1:    res = 1'b1;
      3'd3:    res = 1'b1;
      3'd7:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  state_t               r_state;
  logic [2:0]           r_mast;
  logic [TO_BITS-1:0]   r_wd;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ld_start;
  logic                 r_pd_start;
  logic [1:0]           r_err;
  logic [3:0]           r_sr_cen;
  logic [3:0]           r_sr_wen;
  logic [4*AW-1:0]      r_sr_addr;
  logic [DW-1:0]        r_sr_data;

  logic                 w_pad_own;
  logic                 w_conflict;
  logic [TO_BITS-1:0]   w_wd_inc;
  logic                 w_wd_expire;
  logic                 w_timeout;

  // Write-port owner: pad engine in PADST/PAD, loader everywhere else.
  always_comb begin
    w_pad_own = 1'b0;
    case (r_state)
      ST_PADST: w_pad_own = 1'b1;
      ST_PAD:   w_pad_own = 1'b1;
      default:  w_pad_own = 1'b0;
    endcase
  end

  // Any active-low chip enable from the side that does not own the port is a conflict.
  always_comb begin
    w_conflict = 1'b0;
    if (w_pad_own) begin
      w_conflict = (ld_cen != 4'hF);
    end else begin
      w_conflict = (pd_cen != 4'hF);
    end
  end

  // Watchdog expiry; a done pulse in the expiry cycle suppresses the timeout.
  always_comb begin
    w_wd_inc    = r_wd + TO_BITS'(1);
    w_wd_expire = (w_wd_inc >= TIMEOUT_C);
    w_timeout   = 1'b0;
    case (r_state)
      ST_LOAD: w_timeout = w_wd_expire && !ld_done;
      ST_PAD:  w_timeout = w_wd_expire && !pd_done;
      default: w_timeout = 1'b0;
    endcase
  end

  // Tile sequencing FSM with registered phase strobes and watchdog counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_mast     <= 3'd0;
      r_wd       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_start <= 1'b0;
      r_pd_start <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_ld_start <= 1'b0;
      r_pd_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tile_start) begin
            r_state    <= ST_LOAD;
            r_mast     <= tile_mast;
            r_wd       <= '0;
            r_busy     <= 1'b1;
            r_ld_start <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_done) begin
            r_wd <= '0;
            if (f_needs_pad(r_mast)) begin
              r_state    <= ST_PADST;
              r_pd_start <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= ST_ERR;
            r_wd    <= '0;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        ST_PADST: begin
          r_state <= ST_PAD;
          r_wd    <= '0;
        end
        ST_PAD: begin
          if (pd_done) begin
            r_state <= ST_DONE;
            r_wd    <= '0;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= ST_ERR;
            r_wd    <= '0;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_wd    <= '0;
          r_busy  <= 1'b0;
        end
        ST_ERR: begin
          if (err_clr) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wd    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a clear request beats a same-cycle set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 2'b00;
    end else if (err_clr) begin
      r_err <= 2'b00;
    end else begin
      r_err <= r_err | {w_conflict, w_timeout};
    end
  end

  // Registered SRAM write port, taken from the current owner only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr_cen  <= 4'hF;
      r_sr_wen  <= 4'hF;
      r_sr_addr <= '0;
      r_sr_data <= '0;
    end else if (w_pad_own) begin
      r_sr_cen  <= pd_cen;
      r_sr_wen  <= pd_wen;
      r_sr_addr <= pd_addr;
      r_sr_data <= pd_data;
    end else begin
      r_sr_cen  <= ld_cen;
      r_sr_wen  <= ld_wen;
      r_sr_addr <= ld_addr;
      r_sr_data <= ld_data;
    end
  end

  assign tile_busy = r_busy;
  assign tile_done = r_done;
  assign tile_err  = r_err;
  assign ld_start  = r_ld_start;
  assign pd_start  = r_pd_start;
  assign sr_cen    = r_sr_cen;
  assign sr_wen    = r_sr_wen;
  assign sr_addr   = r_sr_addr;
  assign sr_data   = r_sr_data;

endmodule

// File: tb/tb_ifsram_pd_sched.sv
// Bench for ifsram_pd_sched: directed tile scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// phase/age model of the tile sequencer.
module tb_ifsram_pd_sched;

  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int TB_TO = 31;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_PADST = 2;
  localparam int P_PAD   = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  logic              clk;
  logic              reset;
  logic              tile_start;
  logic [2:0]        tile_mast;
  logic              err_clr;
  logic              tile_busy;
  logic              tile_done;
  logic [1:0]        tile_err;
  logic              ld_start;
  logic              ld_done;
  logic              pd_start;
  logic              pd_done;
  logic [3:0]        ld_cen, ld_wen, pd_cen, pd_wen;
  logic [4*AW-1:0]   ld_addr, pd_addr;
  logic [DW-1:0]     ld_data, pd_data;
  logic [3:0]        sr_cen, sr_wen;
  logic [4*AW-1:0]   sr_addr;
  logic [DW-1:0]     sr_data;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: current phase, cycles spent in it, expected port contents
  int              m_ph;
  int              m_age;
  bit              m_pad_tile;
  logic [1:0]      m_err;
  logic [3:0]      m_cen, m_wen;
  logic [4*AW-1:0] m_addr;
  logic [DW-1:0]   m_data;

  ifsram_pd_sched #(.AW(AW), .DW(DW), .TO_BITS(10), .PD_TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(reset), .tile_start(tile_start), .tile_mast(tile_mast),
    .err_clr(err_clr), .tile_busy(tile_busy), .tile_done(tile_done),
    .tile_err(tile_err), .ld_start(ld_start), .ld_done(ld_done),
    .pd_start(pd_start), .pd_done(pd_done),
    .ld_cen(ld_cen), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data),
    .pd_cen(pd_cen), .pd_wen(pd_wen), .pd_addr(pd_addr), .pd_data(pd_data),
    .sr_cen(sr_cen), .sr_wen(sr_wen), .sr_addr(sr_addr), .sr_data(sr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_age = 0; m_pad_tile = 1'b0; m_err = 2'b00;
    m_cen = 4'hF; m_wen = 4'hF; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    int nph;
    bit own_pad, conf, tmo;
    own_pad = (m_ph == P_PADST) || (m_ph == P_PAD);
    if (own_pad) begin
      m_cen = pd_cen; m_wen = pd_wen; m_addr = pd_addr; m_data = pd_data;
      conf = (ld_cen != 4'hF);
    end else begin
      m_cen = ld_cen; m_wen = ld_wen; m_addr = ld_addr; m_data = ld_data;
      conf = (pd_cen != 4'hF);
    end
    tmo = 1'b0;
    nph = m_ph;
    case (m_ph)
      P_IDLE: if (tile_start) begin
        nph = P_LOAD;
        m_pad_tile = (tile_mast == 3'd1) || (tile_mast == 3'd3) || (tile_mast == 3'd7);
      end
      P_LOAD: begin
        if (ld_done) nph = m_pad_tile ? P_PADST : P_DONE;
        else if (m_age + 1 >= TB_TO) begin tmo = 1'b1; nph = P_ERR; end
      end
      P_PADST: nph = P_PAD;
      P_PAD: begin
        if (pd_done) nph = P_DONE;
        else if (m_age + 1 >= TB_TO) begin tmo = 1'b1; nph = P_ERR; end
      end
      P_DONE: nph = P_IDLE;
      P_ERR: if (err_clr) nph = P_IDLE;
      default: nph = P_IDLE;
    endcase
    if (err_clr) m_err = 2'b00;
    else m_err = m_err | {conf, tmo};
    if (nph != m_ph) m_age = 0;
    else m_age++;
    m_ph = nph;
  endtask

  task automatic compare_all();
    chk("busy",     {63'd0, tile_busy}, {63'd0, m_ph != P_IDLE});
    chk("done",     {63'd0, tile_done}, {63'd0, m_ph == P_DONE});
    chk("ld_start", {63'd0, ld_start},  {63'd0, (m_ph == P_LOAD) && (m_age == 0)});
    chk("pd_start", {63'd0, pd_start},  {63'd0, m_ph == P_PADST});
    chk("tile_err", {62'd0, tile_err},  {62'd0, m_err});
    chk("sr_cen",   {60'd0, sr_cen},    {60'd0, m_cen});
    chk("sr_wen",   {60'd0, sr_wen},    {60'd0, m_wen});
    chk("sr_addr",  {20'd0, sr_addr},   {20'd0, m_addr});
    chk("sr_data",  sr_data,            m_data);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    tile_start = 1'b0; tile_mast = 3'd0; err_clr = 1'b0;
    ld_done = 1'b0; pd_done = 1'b0;
    ld_cen = 4'hF; ld_wen = 4'hF; pd_cen = 4'hF; pd_wen = 4'hF;
    ld_addr = '0; pd_addr = '0; ld_data = '0; pd_data = '0;
  endtask

  task automatic start_tile(input logic [2:0] mast);
    tile_start = 1'b1; tile_mast = mast;
    cycle();
    tile_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) cycle();
    chk("rst_sr_cen", {60'd0, sr_cen}, 64'hF);
    chk("rst_sr_wen", {60'd0, sr_wen}, 64'hF);
    chk("rst_busy", {63'd0, tile_busy}, 64'd0);
    chk("rst_err", {62'd0, tile_err}, 64'd0);
    reset = 1'b1;

    // LEFT tile: load 5 cycles, pad 20 cycles
    start_tile(3'd1);
    chk("t1_ld_start", {63'd0, ld_start}, 64'd1);
    chk("t1_busy", {63'd0, tile_busy}, 64'd1);
    repeat (4) cycle();
    ld_done = 1'b1; cycle(); ld_done = 1'b0;
    chk("t1_pd_start", {63'd0, pd_start}, 64'd1);
    repeat (19) cycle();
    pd_done = 1'b1; cycle(); pd_done = 1'b0;
    chk("t1_done", {63'd0, tile_done}, 64'd1);
    cycle();
    chk("t1_idle_busy", {63'd0, tile_busy}, 64'd0);
    chk("t1_err", {62'd0, tile_err}, 64'd0);

    // NORMAL tile with ld_done on the first LOAD cycle, then mast=5
    start_tile(3'd2);
    ld_done = 1'b1; cycle(); ld_done = 1'b0;
    chk("t2_done", {63'd0, tile_done}, 64'd1);
    chk("t2_no_pd", {63'd0, pd_start}, 64'd0);
    cycle();
    start_tile(3'd5);
    cycle();
    ld_done = 1'b1; cycle(); ld_done = 1'b0;
    chk("t2b_done", {63'd0, tile_done}, 64'd1);
    cycle();

    // write-port muxing and ownership conflict
    start_tile(3'd1);
    ld_cen = 4'b1110; ld_wen = 4'b1110; ld_addr = 44'h10; ld_data = 64'hA5;
    cycle();
    chk("t3_ld_cen", {60'd0, sr_cen}, 64'hE);
    chk("t3_ld_addr", {53'd0, sr_addr[AW-1:0]}, 64'h10);
    ld_cen = 4'hF; ld_wen = 4'hF; ld_done = 1'b1;
    cycle(); ld_done = 1'b0;
    cycle();
    pd_cen = 4'b0111; pd_wen = 4'b0111; pd_data = '0;
    cycle();
    chk("t3_pd_cen", {60'd0, sr_cen}, 64'h7);
    chk("t3_pd_data", sr_data, 64'd0);
    ld_cen = 4'b1110;
    cycle();
    chk("t4_drop", {60'd0, sr_cen}, 64'h7);
    chk("t4_err", {62'd0, tile_err}, 64'h2);
    ld_cen = 4'hF; pd_cen = 4'hF; pd_wen = 4'hF; pd_done = 1'b1;
    cycle(); pd_done = 1'b0;
    chk("t4_done", {63'd0, tile_done}, 64'd1);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("t4_clr", {62'd0, tile_err}, 64'd0);

    // pad watchdog timeout, ignored start in ERR, recovery
    start_tile(3'd3);
    ld_done = 1'b1; cycle(); ld_done = 1'b0;
    cycle();
    repeat (TB_TO - 1) cycle();
    chk("t5_pre_err", {62'd0, tile_err}, 64'd0);
    cycle();
    chk("t5_err", {62'd0, tile_err}, 64'h1);
    start_tile(3'd2);
    chk("t5_ign_start", {63'd0, ld_start}, 64'd0);
    chk("t5_busy", {63'd0, tile_busy}, 64'd1);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("t5_clr_busy", {63'd0, tile_busy}, 64'd0);
    chk("t5_clr_err", {62'd0, tile_err}, 64'd0);

    // asynchronous reset in the middle of PAD
    start_tile(3'd1);
    ld_done = 1'b1; cycle(); ld_done = 1'b0;
    cycle();
    pd_cen = 4'b0111;
    cycle();
    chk("t6_pre_cen", {60'd0, sr_cen}, 64'h7);
    reset = 1'b0;
    #1;
    chk("t6_rst_cen", {60'd0, sr_cen}, 64'hF);
    chk("t6_rst_busy", {63'd0, tile_busy}, 64'd0);
    model_reset();
    pd_cen = 4'hF;
    cycle(); cycle();
    reset = 1'b1;
    start_tile(3'd2);
    chk("t6_restart", {63'd0, ld_start}, 64'd1);
    ld_done = 1'b1; cycle(); ld_done = 1'b0;
    chk("t6_done", {63'd0, tile_done}, 64'd1);
    cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tile_start = ($urandom_range(0, 5) == 0);
      tile_mast  = 3'($urandom_range(0, 7));
      ld_done    = ($urandom_range(0, 19) == 0);
      pd_done    = ($urandom_range(0, 19) == 0);
      err_clr    = ($urandom_range(0, 39) == 0);
      ld_cen     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      pd_cen     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      ld_wen     = 4'($urandom);
      pd_wen     = 4'($urandom);
      ld_addr    = {12'($urandom), $urandom};
      pd_addr    = {12'($urandom), $urandom};
      ld_data    = {$urandom, $urandom};
      pd_data    = {$urandom, $urandom};
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        #1;
        chk("rnd_rst_busy", {63'd0, tile_busy}, 64'd0);
        chk("rnd_rst_cen", {60'd0, sr_cen}, 64'hF);
        model_reset();
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
